// File: rtl/lutnn_pkg.sv
// Shared constants and state encoding for the LUT-network input/output sequencer.
package lutnn_pkg;

    localparam int NET_INPUTS = 400;
    localparam int NET_OUTPUT = 10;
    localparam int CLASS_W    = $clog2(NET_OUTPUT);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/lutnn_prio_enc.sv
// Lowest-set-bit priority encoder with all-zero and more-than-one-set flags.
module lutnn_prio_enc #(
    parameter int W     = 10,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_o,
    output logic             multi_o
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end else begin
                idx_o = idx_o;
            end
        end
        none_o  = ~|vec_i;
        multi_o = |(vec_i & (vec_i - W'(1)));
    end

endmodule

// File: rtl/lutnn_seq.sv
// Assembles a streamed image onto the LUT network input, waits a settle time and
// offers the encoded class on a valid/ready channel. Optional counters: LUTNN_SEQ_STATS_EN.
module lutnn_seq #(
    parameter int NET_INPUTS    = lutnn_pkg::NET_INPUTS,
    parameter int NET_OUTPUT    = lutnn_pkg::NET_OUTPUT,
    parameter int WORD_W        = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_last,
    output logic [NET_INPUTS-1:0]         net_i,
    input  logic [NET_OUTPUT-1:0]         net_o,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(NET_OUTPUT)-1:0] m_class,
    output logic [NET_OUTPUT-1:0]         m_raw,
    output logic                          m_none,
    output logic                          m_multi,
    output logic                          err_framing
`ifdef LUTNN_SEQ_STATS_EN
    ,
    output logic [15:0]                   stat_images,
    output logic [7:0]                    stat_errs
`endif
);

    import lutnn_pkg::*;

    localparam int N      = NET_INPUTS / WORD_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CLS_W  = $clog2(NET_OUTPUT);
    localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(N - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    generate
        if (NET_INPUTS % WORD_W != 0) begin : g_bad_word_w
            $error("lutnn_seq: NET_INPUTS must be a multiple of WORD_W");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("lutnn_seq: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    seq_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SET_W-1:0]        set_q, set_d;
    logic [NET_INPUTS-1:0]   net_q, net_d;
    logic                    m_valid_q, m_valid_d;
    logic [CLS_W-1:0]        m_class_q, m_class_d;
    logic [NET_OUTPUT-1:0]   m_raw_q, m_raw_d;
    logic                    m_none_q, m_none_d;
    logic                    m_multi_q, m_multi_d;
    logic                    err_q, err_d;

    logic [CLS_W-1:0]        enc_idx_s;
    logic                    enc_none_s;
    logic                    enc_multi_s;

    lutnn_prio_enc #(
        .W     (NET_OUTPUT),
        .IDX_W (CLS_W)
    ) u_enc (
        .vec_i   (net_o),
        .idx_o   (enc_idx_s),
        .none_o  (enc_none_s),
        .multi_o (enc_multi_s)
    );

    // Next-state, image assembly, framing checks and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_d     = set_q;
        net_d     = net_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        m_raw_d   = m_raw_q;
        m_none_d  = m_none_q;
        m_multi_d = m_multi_q;
        err_d     = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    // Word 0 lands in the MSBs so the image reads in stream order.
                    net_d[NET_INPUTS - 1 - int'(cnt_q) * WORD_W -: WORD_W] = s_data;
                    if (cnt_q == LAST_K) begin
                        cnt_d = '0;
                        if (s_last) begin
                            state_d = SETTLE;
                            set_d   = '0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    state_d = DRAIN;
                end
            end
            SETTLE: begin
                if (set_q == SET_LAST) begin
                    m_raw_d   = net_o;
                    m_class_d = enc_idx_s;
                    m_none_d  = enc_none_s;
                    m_multi_d = enc_multi_s;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = LOAD;
                    cnt_d     = '0;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d   = LOAD;
                cnt_d     = '0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            set_q     <= '0;
            net_q     <= '0;
            m_valid_q <= 1'b0;
            m_class_q <= '0;
            m_raw_q   <= '0;
            m_none_q  <= 1'b0;
            m_multi_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            set_q     <= set_d;
            net_q     <= net_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            m_raw_q   <= m_raw_d;
            m_none_q  <= m_none_d;
            m_multi_q <= m_multi_d;
            err_q     <= err_d;
        end
    end

    assign s_ready     = !rst && ((state_q == LOAD) || (state_q == DRAIN));
    assign net_i       = net_q;
    assign m_valid     = m_valid_q;
    assign m_class     = m_class_q;
    assign m_raw       = m_raw_q;
    assign m_none      = m_none_q;
    assign m_multi     = m_multi_q;
    assign err_framing = err_q;

`ifdef LUTNN_SEQ_STATS_EN
    logic [15:0] stat_images_q;
    logic [7:0]  stat_errs_q;

    // Result count wraps; error count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_images_q <= 16'd0;
            stat_errs_q   <= 8'd0;
        end else begin
            if (m_valid_q && m_ready) begin
                stat_images_q <= stat_images_q + 16'd1;
            end else begin
                stat_images_q <= stat_images_q;
            end
            if (err_d && (stat_errs_q != 8'd255)) begin
                stat_errs_q <= stat_errs_q + 8'd1;
            end else begin
                stat_errs_q <= stat_errs_q;
            end
        end
    end

    assign stat_images = stat_images_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_lutnn_seq.sv
// Self-checking bench for lutnn_seq: randomized images and network stubs against a reference model.
module tb_lutnn_seq;

    localparam int NI = 400;
    localparam int NO = 10;
    localparam int WW = 16;
    localparam int NW = NI / WW;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [WW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [NI-1:0] net_i;
    logic [NO-1:0] net_o = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [3:0]    m_class;
    logic [NO-1:0] m_raw;
    logic          m_none;
    logic          m_multi;
    logic          err_framing;
`ifdef LUTNN_SEQ_STATS_EN
    logic [15:0]   stat_images;
    logic [7:0]    stat_errs;
`endif

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int mv_seen = 0;
    logic [WW-1:0] words [NW];

    lutnn_seq dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .net_i       (net_i),
        .net_o       (net_o),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_class     (m_class),
        .m_raw       (m_raw),
        .m_none      (m_none),
        .m_multi     (m_multi),
        .err_framing (err_framing)
`ifdef LUTNN_SEQ_STATS_EN
        ,
        .stat_images (stat_images),
        .stat_errs   (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_framing === 1'b1) err_seen++;
        if (m_valid === 1'b1) mv_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Reference model: the image is the words concatenated in stream order.
    function automatic logic [NI-1:0] model_image();
        logic [NI-1:0] img = '0;
        for (int k = 0; k < NW; k++) img = (img << WW) | NI'(words[k]);
        return img;
    endfunction

    function automatic int model_class(input logic [NO-1:0] v);
        for (int i = 0; i < NO; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
    endtask

    task automatic send_words(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            int w;
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = words[i % NW];
            s_last  = (i == last_idx);
            w = 0;
            while (s_ready !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: word %0d s_ready=%b want 1", i, s_ready);
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    // Called one cycle after the last handshake; ends with the result still offered.
    task automatic await_result(input logic [NO-1:0] stub, input string tag);
        for (int c = 0; c < SC; c++) begin
            checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s settle_c%0d: m_valid=%b s_ready=%b want 0 0", tag, c, m_valid, s_ready);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s m_valid: got %b want 1", tag, m_valid);
        end
        checks++;
        if (m_class !== 4'(model_class(stub)) || m_none !== (stub == '0) ||
            m_multi !== ($countones(stub) > 1) || m_raw !== stub) begin
            errors++;
            $display("FAIL %s result: class=%0d none=%b multi=%b raw=%b want %0d %b %b %b", tag,
                     m_class, m_none, m_multi, m_raw, model_class(stub), (stub == '0),
                     ($countones(stub) > 1), stub);
        end
        checks++;
        if (net_i !== model_image()) begin
            errors++;
            $display("FAIL %s net_i: got %h want %h", tag, net_i, model_image());
        end
    endtask

    task automatic consume(input string tag);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s consume: m_valid=%b s_ready=%b want 0 1", tag, m_valid, s_ready);
        end
    endtask

    task automatic clean_image(input logic [NO-1:0] stub, input string tag);
        fill_random();
        net_o = stub;
        send_words(NW, NW - 1);
        await_result(stub, tag);
        consume(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_class !== 4'd0 || m_raw !== '0 ||
                m_none !== 1'b0 || m_multi !== 1'b0 || err_framing !== 1'b0 || net_i !== '0) begin
                errors++;
                $display("FAIL reset_c%0d: s_ready=%b m_valid=%b class=%0d raw=%b none=%b multi=%b err=%b net_i_nz=%b want all 0",
                         c, s_ready, m_valid, m_class, m_raw, m_none, m_multi, err_framing, |net_i);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release s_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic test_nominal();
        fill_random();
        words[0] = 16'h003C;
        words[1] = 16'h0007;
        net_o = 10'b0010000000;
        send_words(NW, NW - 1);
        await_result(10'b0010000000, "nominal");
        consume("nominal");
    endtask

    task automatic test_backpressure();
        logic [NO-1:0] stub;
        fill_random();
        stub  = NO'($urandom) | 10'b0000000001;
        net_o = stub;
        send_words(NW, NW - 1);
        await_result(stub, "bp");
        for (int c = 0; c < 10; c++) begin
            net_o   = NO'($urandom);
            s_valid = 1'b1;
            s_last  = 1'b1;
            s_data  = WW'($urandom);
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_raw !== stub || m_class !== 4'(model_class(stub)) ||
                s_ready !== 1'b0 || net_i !== model_image()) begin
                errors++;
                $display("FAIL bp_stall_c%0d: m_valid=%b raw=%b class=%0d s_ready=%b want 1 %b %0d 0",
                         c, m_valid, m_raw, m_class, s_ready, stub, model_class(stub));
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        consume("bp");
    endtask

    task automatic test_early_last();
        int e0;
        e0 = err_seen;
        fill_random();
        send_words(6, 5);
        checks++;
        if (err_framing !== 1'b1) begin
            errors++;
            $display("FAIL early_pulse: err_framing=%b want 1", err_framing);
        end
        tick();
        checks++;
        if (err_framing !== 1'b0 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL early_count: err_framing=%b pulses=%0d want 0 1", err_framing, err_seen - e0);
        end
        clean_image(NO'($urandom), "early_after");
    endtask

    task automatic test_missing_last();
        int e0, mv0;
        e0  = err_seen;
        mv0 = mv_seen;
        fill_random();
        send_words(NW + 3, NW + 2);
        tick();
        tick();
        checks++;
        if (err_seen - e0 != 1 || mv_seen != mv0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL missing_last: pulses=%0d m_valid_cycles=%0d s_ready=%b want 1 0 1",
                     err_seen - e0, mv_seen - mv0, s_ready);
        end
        clean_image(NO'($urandom), "missing_after");
    endtask

    task automatic test_flags();
        logic [NO-1:0] stubs [5];
        stubs[0] = 10'b0000000000;
        stubs[1] = 10'b0000100100;
        stubs[2] = 10'b1000000000;
        stubs[3] = NO'($urandom);
        stubs[4] = NO'($urandom);
        for (int i = 0; i < 5; i++) clean_image(stubs[i], $sformatf("flags%0d", i));
    endtask

    task automatic test_reset_settle();
        int mv0;
        fill_random();
        net_o = 10'b0000000010;
        send_words(NW, NW - 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mv0 = mv_seen;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (mv_seen != mv0 || m_valid !== 1'b0 || s_ready !== 1'b1 || net_i !== '0) begin
            errors++;
            $display("FAIL reset_settle: m_valid_cycles=%0d m_valid=%b s_ready=%b net_i_nz=%b want 0 0 1 0",
                     mv_seen - mv0, m_valid, s_ready, |net_i);
        end
        clean_image(NO'($urandom), "reset_after");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_flags();
        test_reset_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lutnn_seq.md
# lutnn_seq

Sequencer that feeds the combinational LUT network (`top`, 400-bit `NET_I` / 10-bit `NET_O`) from a narrow streaming source. It assembles one binarized 20x20 image from fixed-width words and holds it stable on the network input for a programmable settle time. It then captures the network output, encodes the winning class, and offers the result on a valid/ready output channel. It sits between the image DMA/stream front-end and the `top` instance.

## Interface
- `NET_INPUTS`, 400: image width in bits.
- `NET_OUTPUT`, 10: network output width (one bit per class).
- `WORD_W`, 16: input stream word width. `NET_INPUTS % WORD_W == 0` is required; the block raises an elaboration error otherwise.
- `SETTLE_CYCLES`, 2: cycles the image is held before capture. Must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when `s_valid && s_ready`.
- `s_data`  in  WORD_W  image word.
- `s_last`  in  1  marks the final word of an image.
- `net_i`  out  NET_INPUTS  registered image, wired to `top.NET_I`.
- `net_o`  in  NET_OUTPUT  wired from `top.NET_O`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed when `m_valid && m_ready`.
- `m_class`  out  CLASS_W=$clog2(NET_OUTPUT)  index of the lowest set bit of the captured output.
- `m_raw`  out  NET_OUTPUT  captured `net_o`.
- `m_none`  out  1  captured output was all zeros.
- `m_multi`  out  1  captured output had more than one bit set.
- `err_framing`  out  1  one-cycle pulse on a framing error.

## Operation
- The block has four states: LOAD, DRAIN, SETTLE, OUT. Reset enters LOAD with word count 0.
- LOAD:
  - `s_ready`=1.
  - The word at count k is written to `net_i[NET_INPUTS-1-k*WORD_W -: WORD_W]`, so word 0 lands in the MSBs and the image hex reads in stream order.
  - The count increments on each handshake. N = NET_INPUTS/WORD_W.
- Last-word rules in LOAD:
  - Handshake with k==N-1 and `s_last`=1: go to SETTLE with the settle counter at 0.
  - `s_last`=1 with k<N-1 (early last): pulse `err_framing`, reset the count, stay in LOAD. The partial image is discarded. `net_i` is not cleared and will be overwritten.
  - k==N-1 with `s_last`=0 (missing last): pulse `err_framing`, go to DRAIN.
- DRAIN: `s_ready`=1. Words are discarded until a handshake with `s_last`=1, then the block returns to LOAD with count 0.
- SETTLE:
  - `s_ready`=0 and `net_i` is frozen.
  - The counter increments each cycle.
  - On the cycle the counter equals SETTLE_CYCLES-1, the block captures `net_o` into `m_raw`, computes `m_class`, `m_none` and `m_multi`, and goes to OUT.
- OUT:
  - `m_valid`=1. All `m_*` outputs are held stable until the handshake.
  - On handshake, go to LOAD with count 0.
  - `s_ready`=0 throughout OUT; there is no overlap of load and output.
- Class encoding: `m_class` is the lowest set index. When `m_none`=1, `m_class`=0.
- Reset mid-operation: any state returns to LOAD next cycle and the partial image is lost.
- Reset values: `net_i`=0, `m_valid`=0, `m_class`=0, `m_raw`=0, `m_none`=0, `m_multi`=0, `err_framing`=0. `s_ready`=0 while `rst`=1.

## Timing
- `s_ready` is decoded from registered state. It is 1 in the first cycle after `rst` deasserts.
- Let the last-word handshake occur on edge E. SETTLE occupies the cycles after E through E+SETTLE_CYCLES. `m_valid` rises after edge E+SETTLE_CYCLES.
- Throughput is one image per N + SETTLE_CYCLES + 1 cycles with `m_ready` tied high. The +1 is the OUT cycle.
- `err_framing` is registered. It is high for exactly the cycle after the offending handshake.
- `m_ready` held low stalls the block in OUT indefinitely with no loss. `s_valid` is ignored in SETTLE and OUT.

## Configuration
- `LUTNN_SEQ_STATS_EN` defined: adds output ports `stat_images` (16 bits, wrapping; increments on each `m_*` handshake) and `stat_errs` (8 bits, saturating at 255; increments on each `err_framing` pulse). Both reset to 0.
- `LUTNN_SEQ_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `lutnn_pkg` holds:
  - constants NET_INPUTS and NET_OUTPUT;
  - `CLASS_W`;
  - the state enum `seq_state_t` {LOAD, DRAIN, SETTLE, OUT}.
- Sub-module `lutnn_prio_enc` (combinational, parameterized width) takes the captured vector and returns the lowest-set index, a none flag and a multi flag. It is instantiated once.

## Test plan
- Reset and idle: hold `rst` 3 cycles. Every listed output must read its reset value. `s_ready` must be 1 on the first cycle after `rst` falls.
- Nominal: stream 25 words of the "seven" image (0x003C, 0x0007, ...) with `s_last` on word 24, using a stub `net_o` = 10'b0010000000.
  - `net_i` must equal the full 400-bit image.
  - `m_valid` must rise 2 cycles after the last handshake, with `m_class`=7, `m_none`=0 and `m_multi`=0.
- Backpressure: hold `m_ready`=0 for 10 cycles.
  - `m_*` must be stable and `s_ready`=0 throughout.
  - After release, `s_ready`=1 on the next cycle.
- Early last: assert `s_last` on word 5. Expect one `err_framing` pulse. A following clean 25-word image must produce a correct result.
- Missing last: send 25 words with no `s_last`, then 3 more words ending with `s_last`. Expect exactly one `err_framing` pulse, no `m_valid`, and a return to LOAD.
- Output flags and reset: stub `net_o`=0 must give `m_none`=1 and `m_class`=0. Stub `net_o`=10'b0000100100 must give `m_class`=2 and `m_multi`=1. Asserting `rst` during SETTLE must suppress `m_valid`.
